spell_sram_port: RTL

- Byte-wide request/ready front end to the 32-bit shared-RAM wishbone master port.
- Sits directly downstream of the spell memory unit's SRAM path; drives the rambus_wb_* signals of the spell top level.
- Handles lane selection, write-data replication and read-byte extraction.
- Adds a one-word write-through read buffer and an ack timeout, so a missing RAM ack cannot hang the core.

---
 rtl/spell_sram_port_pkg.sv | 12 +
 rtl/spell_sram_port.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spell_sram_port_pkg.sv
// rtl/spell_sram_port_pkg.sv - shared spell SRAM port types and constants
package spell_sram_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } sram_state_e;

  localparam logic [7:0] SRAM_ERR_BYTE = 8'hFF;

endpackage

// File: rtl/spell_sram_port.sv
// rtl/spell_sram_port.sv - byte request front end to the 32-bit shared-RAM wishbone port
// Adds a one-word write-through read buffer and an ack timeout.
module spell_sram_port
  import spell_sram_port_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 8,
  parameter int unsigned           RAM_ADDR_W = 10,
  parameter logic [RAM_ADDR_W-1:0] BASE_WORD  = '0,
  parameter int unsigned           TIMEOUT    = 255,
  parameter bit                    CACHE_EN   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_write,
  input  logic                  req_type_data,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  ready,
  output logic [7:0]            rdata,
  output logic                  err,
  input  logic                  flush,
  output logic                  rambus_wb_stb_o,
  output logic                  rambus_wb_cyc_o,
  output logic                  rambus_wb_we_o,
  output logic [3:0]            rambus_wb_sel_o,
  output logic [31:0]           rambus_wb_dat_o,
  output logic [RAM_ADDR_W-1:0] rambus_wb_addr_o,
  input  logic                  rambus_wb_ack_i,
  input  logic [31:0]           rambus_wb_dat_i
);

  localparam int          TAG_W    = int'(ADDR_W) - 1;
  localparam int          SUM_W    = (TAG_W > int'(RAM_ADDR_W)) ? TAG_W + 1 : int'(RAM_ADDR_W) + 1;
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [31:0] CNT_LAST = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

  sram_state_e           state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           dat_q, dat_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic                  ready_q, ready_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [1:0]            lane_q, lane_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]      buf_tag_q, buf_tag_d;
  logic [31:0]           buf_word_q, buf_word_d;

  logic [TAG_W-1:0]      req_tag;
  logic [1:0]            req_lane;
  logic [SUM_W-1:0]      word_sum;
  logic [RAM_ADDR_W-1:0] word_addr;
  logic                  hit;
  logic                  timeout_hit;

  // Word address wraps modulo the RAM address space.
  assign req_tag     = {req_type_data, req_addr[ADDR_W-1:2]};
  assign req_lane    = req_addr[1:0];
  assign word_sum    = SUM_W'(BASE_WORD) + SUM_W'(req_tag);
  assign word_addr   = word_sum[RAM_ADDR_W-1:0];
  assign hit         = CACHE_EN && !req_write && !flush && buf_valid_q && (buf_tag_q == req_tag);
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      dat_q       <= '0;
      addr_q      <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lane_q      <= '0;
      tag_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      addr_q      <= addr_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      lane_q      <= lane_d;
      tag_q       <= tag_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_word_q  <= buf_word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    addr_d      = addr_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    lane_d      = lane_q;
    tag_d       = tag_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_word_d  = buf_word_q;

    if (flush) buf_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          lane_d = req_lane;
          tag_d  = req_tag;
          if (hit) begin
            rdata_d = buf_word_q[8*req_lane +: 8];
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = req_write;
            sel_d   = 4'b0001 << req_lane;
            dat_d   = {4{req_wdata}};
            addr_d  = word_addr;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (rambus_wb_ack_i) begin
          if (!we_q) begin
            rdata_d     = rambus_wb_dat_i[8*lane_q +: 8];
            buf_word_d  = rambus_wb_dat_i;
            buf_tag_d   = tag_q;
            buf_valid_d = !flush;
          end else if (buf_valid_q && (buf_tag_q == tag_q)) begin
            buf_word_d[8*lane_q +: 8] = dat_q[7:0];
          end
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          ready_d = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          rdata_d = SRAM_ERR_BYTE;
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready            = ready_q;
  assign rdata            = rdata_q;
  assign err              = err_q;
  assign rambus_wb_stb_o  = stb_q;
  assign rambus_wb_cyc_o  = cyc_q;
  assign rambus_wb_we_o   = we_q;
  assign rambus_wb_sel_o  = sel_q;
  assign rambus_wb_dat_o  = dat_q;
  assign rambus_wb_addr_o = addr_q;

endmodule
